// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// operands consumed LSB-first, WIDTH+2 cycles per accepted operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_nxt;

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell on the current LSBs; the new sum bit enters at the MSB
  always_comb begin
    bit_s   = fa_sum(a_sr[0], b_sr[0], c_reg);
    bit_c   = fa_carry(a_sr[0], b_sr[0], c_reg);
    sum_nxt = sum_sr >> 1;
    sum_nxt[WIDTH-1] = bit_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      c_reg    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1; cin only matters for add
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            c_reg <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c_reg  <= bit_c;
          sum_sr <= sum_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // c_reg is the carry into the MSB here, bit_c the carry out of it
            sum      <= sum_nxt;
            carry    <= bit_c;
            overflow <= c_reg ^ bit_c;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
